// File: rtl/mbist_addr_gen_if.sv
// mbist_addr_gen_if: start/busy/done handshake and address bus of the MBIST address generator
interface mbist_addr_gen_if #(parameter int length = 4);
  logic start, u_d, cen, ld, cout, busy, done;
  logic [length-1:0] d_in, lo, hi, q;
  modport master(output start, u_d, cen, ld, d_in, lo, hi, input q, cout, busy, done);
  modport slave(input start, u_d, cen, ld, d_in, lo, hi, output q, cout, busy, done);
endinterface

// File: rtl/mbist_addr_gen.sv
// mbist_addr_gen: bounded up/down address sweep with start/busy/done handshake.
// Define MBIST_ADDR_GEN_GRAY_EN to present q in Gray code (internal state stays binary).
module mbist_addr_gen #(
  parameter int length = 4,
  parameter bit WRAP   = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  mbist_addr_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [length-1:0] addr_q, addr_d, lo_q, lo_d, hi_q, hi_d;
  logic dir_q, dir_d, done_q, done_d, at_term;
  assign at_term = addr_q == (dir_q ? hi_q : lo_q);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dir_d   = dir_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    done_d  = 1'b0;
    if (bus.start) begin
      dir_d   = bus.u_d;
      lo_d    = bus.lo;
      hi_d    = bus.hi;
      addr_d  = bus.u_d ? bus.lo : bus.hi;
      state_d = RUN;
    end else begin
      if (bus.ld) addr_d = bus.d_in;
      if (state_q == DONE) state_d = IDLE;
      else if (state_q == RUN && bus.cen && !bus.ld) begin
        if (!at_term) addr_d = dir_q ? addr_q + 1'b1 : addr_q - 1'b1;
        else begin
          // done registers here so it shows the cycle after the terminal address in both modes
          done_d = 1'b1;
          if (WRAP) addr_d = dir_q ? lo_q : hi_q;
          else state_d = DONE;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      dir_q   <= 1'b1;
      lo_q    <= '0;
      hi_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dir_q   <= dir_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      done_q  <= done_d;
    end
  end
  assign bus.busy = state_q == RUN;
  assign bus.cout = bus.busy & at_term;
  assign bus.done = done_q;
`ifdef MBIST_ADDR_GEN_GRAY_EN
  assign bus.q = addr_q ^ (addr_q >> 1);
`else
  assign bus.q = addr_q;
`endif
endmodule
